silife_max7219_sink: RTL

SILIFE_MAX7219_SINK -- requirements
Module: silife_max7219_sink

---
 rtl/silife_max7219_sink.sv | 113 +++++++++++
 1 files changed

// File: rtl/silife_max7219_sink.sv
// MAX7219-style SPI sink: 16-bit frames latched on CS rise into an 8x8 framebuffer and control registers.
// Latency: ~3 clk from pin edge to effect through the synchronizers; no backpressure, SPI timing must respect min SCK phases.
module silife_max7219_sink (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_cs,
    input  logic        i_sck,
    input  logic        i_mosi,
    output logic        o_dout,
    input  logic [2:0]  i_rd_row,
    output logic [7:0]  o_rd_data,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic [7:0]  o_decode_mode,
    output logic        o_shutdown,
    output logic        o_test,
    output logic [15:0] o_word,
    output logic        o_word_valid,
    output logic        o_err
);

    logic        cs_meta, cs_sync, cs_prev;
    logic        sck_meta, sck_sync, sck_prev;
    logic        mosi_meta, mosi_sync;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        armed;
    logic [7:0]  rows [8];

    logic sck_rise, cs_fall, cs_rise, shift_en;

    assign sck_rise = sck_sync & ~sck_prev;
    assign cs_fall  = ~cs_sync & cs_prev;
    assign cs_rise  = cs_sync & ~cs_prev;
    // armed stays clear after a mid-frame reset until CS has been seen high
    assign shift_en = sck_rise & ~cs_sync & armed;

    assign o_dout    = shift_reg[15];
    assign o_rd_data = rows[i_rd_row];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_meta       <= 1'b0;
            cs_sync       <= 1'b0;
            cs_prev       <= 1'b0;
            sck_meta      <= 1'b0;
            sck_sync      <= 1'b0;
            sck_prev      <= 1'b0;
            mosi_meta     <= 1'b0;
            mosi_sync     <= 1'b0;
            shift_reg     <= 16'h0000;
            bit_cnt       <= 5'd0;
            armed         <= 1'b0;
            o_word        <= 16'h0000;
            o_word_valid  <= 1'b0;
            o_err         <= 1'b0;
            o_intensity   <= 4'h0;
            o_scan_limit  <= 3'h0;
            o_decode_mode <= 8'h00;
            o_shutdown    <= 1'b1;
            o_test        <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                rows[r] <= 8'h00;
            end
        end else begin
            cs_meta   <= i_cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sck_meta  <= i_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= i_mosi;
            mosi_sync <= mosi_meta;

            o_word_valid <= 1'b0;
            o_err        <= 1'b0;

            if (cs_sync) begin
                armed <= 1'b1;
            end

            if (shift_en) begin
                shift_reg <= {shift_reg[14:0], mosi_sync};
            end

            if (cs_fall) begin
                bit_cnt <= 5'd0;
            end else if (shift_en && bit_cnt != 5'd16) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (cs_rise && armed) begin
                if (bit_cnt == 5'd16) begin
                    o_word       <= shift_reg;
                    o_word_valid <= 1'b1;
                    case (shift_reg[11:8])
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: rows[shift_reg[10:8] - 3'd1] <= shift_reg[7:0];
                        4'h9:    o_decode_mode <= shift_reg[7:0];
                        4'hA:    o_intensity   <= shift_reg[3:0];
                        4'hB:    o_scan_limit  <= shift_reg[2:0];
                        4'hC:    o_shutdown    <= ~shift_reg[0];
                        4'hF:    o_test        <= shift_reg[0];
                        default: ;
                    endcase
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule
